merge_engine_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 128-element serial merge stage among NUM_REQ requesters.
- The merge stage merges two 64-element sorted runs into one 128-element descending run and has no ready signal. This block launches one job at a time, holds the operand stable, waits for completion, routes the result back to the owner, and guards each job with a watchdog.
- Sits between the per-channel sort front-ends and the single shared merge stage.

---
 rtl/merge_engine_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/merge_engine_arbiter.sv
// merge_engine_arbiter
//   Round-robin arbiter and job sequencer that shares one serial 128-element
//   merge stage among NUM_REQ requesters. One job is outstanding at a time;
//   each job is guarded by a watchdog of TIMEOUT cycles.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req             per-requester request level
//   req_data        operand of requester i at [i*128*DATA_WIDTH +: 128*DATA_WIDTH]
//   gnt             one-hot one-cycle accept pulse
//   done            one-hot one-cycle completion pulse, rsp_data valid
//   err             one-hot one-cycle timeout pulse
//   rsp_data        merged result, held until next completion
//   busy            high while a job is launched or running
//   eng_idata       operand to the merge stage, held from grant to next grant
//   eng_ivalid      one-cycle start pulse to the merge stage
//   eng_odata       merge stage result
//   eng_ovalid      merge stage completion pulse
module merge_engine_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*128*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic [NUM_REQ-1:0]              err,
    output logic [128*DATA_WIDTH-1:0]       rsp_data,
    output logic                            busy,
    output logic [128*DATA_WIDTH-1:0]       eng_idata,
    output logic                            eng_ivalid,
    input  logic [128*DATA_WIDTH-1:0]       eng_odata,
    input  logic                            eng_ovalid
);

    localparam int unsigned OP_W  = 128 * DATA_WIDTH;
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last;
    logic [TMR_W-1:0]   timer;

    logic [IDX_W-1:0]   win_c;
    logic               win_vld_c;
    int unsigned        idx;

    // Round-robin search: first set request starting at last+1, wrapping.
    always_comb begin
        win_c     = '0;
        win_vld_c = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(last) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_vld_c && req[IDX_W'(idx)]) begin
                win_vld_c = 1'b1;
                win_c     = IDX_W'(idx);
            end
        end
    end

    // Job sequencer: grant, launch, wait for completion or watchdog expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last       <= IDX_W'(NUM_REQ - 1);
            timer      <= '0;
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            eng_idata  <= '0;
            eng_ivalid <= 1'b0;
        end else begin
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            eng_ivalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld_c) begin
                        eng_idata  <= req_data[32'(win_c)*OP_W +: OP_W];
                        owner      <= win_c;
                        last       <= win_c;
                        gnt        <= NUM_REQ'(1) << win_c;
                        eng_ivalid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    timer <= timer + TMR_W'(1);
                    // Completion takes priority over a coincident timeout.
                    if (eng_ovalid) begin
                        rsp_data <= eng_odata;
                        done     <= NUM_REQ'(1) << owner;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        err   <= NUM_REQ'(1) << owner;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
